// File: rtl/wb_core_arbiter.sv
// Two-to-one Wishbone B4 pipelined arbiter: fetch and LSU masters share one bus port.
// Ownership is held for a whole bus cycle; outstanding requests are tracked per owner.
module wb_core_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                if_cyc_i,
  input  logic                if_stb_i,
  input  logic                if_we_i,
  input  logic [ADDR_W-1:0]   if_adr_i,
  input  logic [DATA_W/8-1:0] if_sel_i,
  input  logic [DATA_W-1:0]   if_dat_i,
  output logic [DATA_W-1:0]   if_dat_o,
  output logic                if_ack_o,
  output logic                if_err_o,
  output logic                if_stall_o,
  input  logic                lsu_cyc_i,
  input  logic                lsu_stb_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_adr_i,
  input  logic [DATA_W/8-1:0] lsu_sel_i,
  input  logic [DATA_W-1:0]   lsu_dat_i,
  output logic [DATA_W-1:0]   lsu_dat_o,
  output logic                lsu_ack_o,
  output logic                lsu_err_o,
  output logic                lsu_stall_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_stall_i
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_LSU} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;   // 1: LSU was granted most recently
  logic [CNT_W-1:0] r_outst;

  logic w_own_cyc;
  logic w_own_stb;
  logic w_full;
  logic w_arb;
  logic w_resp_ok;
  logic w_inc;
  logic w_dec;

  function automatic logic [CNT_W-1:0] f_next_outst(input logic [CNT_W-1:0] cur,
                                                    input logic inc, input logic dec);
    if (inc && !dec)
      return cur + CNT_W'(1);
    else if (dec && !inc && cur != '0)
      return cur - CNT_W'(1);
    return cur;
  endfunction

  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_sel_o   = '0;
    s_dat_o   = '0;
    case (r_state)
      GNT_IF: begin
        w_own_cyc = if_cyc_i;
        w_own_stb = if_stb_i;
        s_we_o    = if_we_i;
        s_adr_o   = if_adr_i;
        s_sel_o   = if_sel_i;
        s_dat_o   = if_dat_i;
      end
      GNT_LSU: begin
        w_own_cyc = lsu_cyc_i;
        w_own_stb = lsu_stb_i;
        s_we_o    = lsu_we_i;
        s_adr_o   = lsu_adr_i;
        s_sel_o   = lsu_sel_i;
        s_dat_o   = lsu_dat_i;
      end
      default: ;
    endcase
  end

  assign w_full  = (r_outst == C_MAX);
  assign s_cyc_o = w_own_cyc;
  assign s_stb_o = w_own_cyc & w_own_stb & ~w_full;

  // Responses with nothing outstanding (late acks after an abort) are dropped.
  assign w_resp_ok = s_cyc_o & (r_outst != '0);
  assign w_inc     = s_stb_o & ~s_stall_i;
  assign w_dec     = (s_ack_i | s_err_i) & w_resp_ok;

  assign if_dat_o    = s_dat_i;
  assign lsu_dat_o   = s_dat_i;
  assign if_ack_o    = (r_state == GNT_IF)  & s_ack_i & w_resp_ok;
  assign if_err_o    = (r_state == GNT_IF)  & s_err_i & w_resp_ok;
  assign lsu_ack_o   = (r_state == GNT_LSU) & s_ack_i & w_resp_ok;
  assign lsu_err_o   = (r_state == GNT_LSU) & s_err_i & w_resp_ok;
  assign if_stall_o  = (r_state == GNT_IF)  ? (s_stall_i | w_full) : 1'b1;
  assign lsu_stall_o = (r_state == GNT_LSU) ? (s_stall_i | w_full) : 1'b1;

  // Arbitrate in IDLE or whenever the current owner has released cyc.
  assign w_arb = ~w_own_cyc;

  always_comb begin
    w_next = r_state;
    if (w_arb) begin
      case ({if_cyc_i, lsu_cyc_i})
        2'b10:   w_next = GNT_IF;
        2'b01:   w_next = GNT_LSU;
        2'b11:   w_next = r_last ? GNT_IF : GNT_LSU;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_outst <= '0;
    end else begin
      r_state <= w_next;
      if (w_arb) begin
        r_outst <= '0;
        if (w_next == GNT_IF)
          r_last <= 1'b0;
        else if (w_next == GNT_LSU)
          r_last <= 1'b1;
      end else begin
        r_outst <= f_next_outst(r_outst, w_inc, w_dec);
      end
    end
  end

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Directed bench for wb_core_arbiter: grant, fairness, outstanding limit, abort and reset.
module tb_wb_core_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_cyc, if_stb, if_we;
  logic [AW-1:0] if_adr;
  logic [SW-1:0] if_sel;
  logic [DW-1:0] if_dat_w, if_dat_r;
  logic          if_ack, if_err, if_stall;
  logic          lsu_cyc, lsu_stb, lsu_we;
  logic [AW-1:0] lsu_adr;
  logic [SW-1:0] lsu_sel;
  logic [DW-1:0] lsu_dat_w, lsu_dat_r;
  logic          lsu_ack, lsu_err, lsu_stall;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_dat_w, s_dat_r;
  logic          s_ack, s_err, s_stall;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  wb_core_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .if_cyc_i(if_cyc), .if_stb_i(if_stb), .if_we_i(if_we),
    .if_adr_i(if_adr), .if_sel_i(if_sel), .if_dat_i(if_dat_w),
    .if_dat_o(if_dat_r), .if_ack_o(if_ack), .if_err_o(if_err), .if_stall_o(if_stall),
    .lsu_cyc_i(lsu_cyc), .lsu_stb_i(lsu_stb), .lsu_we_i(lsu_we),
    .lsu_adr_i(lsu_adr), .lsu_sel_i(lsu_sel), .lsu_dat_i(lsu_dat_w),
    .lsu_dat_o(lsu_dat_r), .lsu_ack_o(lsu_ack), .lsu_err_o(lsu_err), .lsu_stall_o(lsu_stall),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_sel_o(s_sel), .s_dat_o(s_dat_w),
    .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    if_cyc = 0; if_stb = 0; if_we = 0; if_adr = '0; if_sel = '0; if_dat_w = '0;
    lsu_cyc = 0; lsu_stb = 0; lsu_we = 0; lsu_adr = '0; lsu_sel = '0; lsu_dat_w = '0;
    s_dat_r = '0; s_ack = 0; s_err = 0; s_stall = 0;
    #2;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_if_stall", if_stall, 1);
    chk("rst_lsu_stall", lsu_stall, 1);
    tick(); rstn = 1'b1;
    tick();

    // 1: fetch issues three pipelined reads, acks two cycles behind
    if_cyc = 1; if_stb = 1; if_adr = 32'h0; if_sel = 4'hf; settle();
    chk("t1_idle_cyc", s_cyc, 0);
    tick(); settle();
    chk("t1_gnt_cyc", s_cyc, 1);
    chk("t1_gnt_stb", s_stb, 1);
    chk("t1_adr0", s_adr, 32'h0);
    chk("t1_if_stall", if_stall, 0);
    chk("t1_lsu_stall_a", lsu_stall, 1);
    tick(); if_adr = 32'h4; settle();
    chk("t1_adr4", s_adr, 32'h4);
    chk("t1_no_ack", if_ack, 0);
    tick(); if_adr = 32'h8; s_ack = 1; s_dat_r = 32'hA0; settle();
    chk("t1_ack0", if_ack, 1);
    chk("t1_dat0", if_dat_r, 32'hA0);
    chk("t1_lsu_ack", lsu_ack, 0);
    chk("t1_lsu_stall_b", lsu_stall, 1);
    tick(); if_stb = 0; s_dat_r = 32'hA1; settle();
    chk("t1_ack1", if_ack, 1);
    chk("t1_dat1", if_dat_r, 32'hA1);
    chk("t1_stb_off", s_stb, 0);
    tick(); s_dat_r = 32'hA2; settle();
    chk("t1_ack2", if_ack, 1);
    chk("t1_dat2", if_dat_r, 32'hA2);
    chk("t1_lsu_stall_c", lsu_stall, 1);
    tick(); s_ack = 0; if_cyc = 0; settle();
    chk("t1_release", s_cyc, 0);
    chk("t1_ack_done", if_ack, 0);

    // 2: tie after reset, handover, second tie
    rstn = 0; settle(); rstn = 1;
    tick(); if_cyc = 1; lsu_cyc = 1; if_adr = 32'h1000; lsu_adr = 32'h2000; settle();
    chk("t2_idle", s_cyc, 0);
    tick(); settle();
    chk("t2_if_cyc", s_cyc, 1);
    chk("t2_if_adr", s_adr, 32'h1000);
    chk("t2_if_stall", if_stall, 0);
    chk("t2_lsu_wait", lsu_stall, 1);
    tick(); if_cyc = 0; settle();
    chk("t2_gap", s_cyc, 0);
    tick(); settle();
    chk("t2_lsu_cyc", s_cyc, 1);
    chk("t2_lsu_adr", s_adr, 32'h2000);
    chk("t2_lsu_stall", lsu_stall, 0);
    chk("t2_if_blocked", if_stall, 1);
    tick(); lsu_cyc = 0; settle();
    chk("t2_lsu_rel", s_cyc, 0);
    tick(); if_cyc = 1; lsu_cyc = 1; settle();
    tick(); settle();
    chk("t2_tie2_adr", s_adr, 32'h1000);
    chk("t2_tie2_if", if_stall, 0);
    tick(); if_cyc = 0; lsu_cyc = 0; settle();

    // 3: six stores against a withheld ack, limit 4
    tick(); lsu_cyc = 1; lsu_stb = 1; lsu_we = 1; lsu_sel = 4'hf;
    lsu_adr = 32'h100; lsu_dat_w = 32'hD0; settle();
    chk("t3_idle_stb", s_stb, 0);
    tick(); settle();
    chk("t3_stb", s_stb, 1);
    chk("t3_we", s_we, 1);
    chk("t3_dat", s_dat_w, 32'hD0);
    chk("t3_sel", s_sel, 4'hf);
    for (int i = 1; i < 4; i++) begin
      tick(); lsu_adr = 32'h100 + 32'(4 * i); lsu_dat_w = 32'hD0 + 32'(i); settle();
      chk("t3_accept", lsu_stall, 0);
    end
    tick(); lsu_adr = 32'h110; lsu_dat_w = 32'hD4; settle();
    chk("t3_full_stall", lsu_stall, 1);
    chk("t3_full_stb", s_stb, 0);
    chk("t3_full_cnt", dut.r_outst, 4);
    tick(); s_ack = 1; settle();
    chk("t3_ack", lsu_ack, 1);
    chk("t3_ack_stb", s_stb, 0);
    tick(); s_ack = 0; settle();
    chk("t3_release1", s_stb, 1);
    chk("t3_release1_adr", s_adr, 32'h110);
    tick(); lsu_adr = 32'h114; lsu_dat_w = 32'hD5; s_err = 1; settle();
    chk("t3_full2", lsu_stall, 1);
    chk("t3_err", lsu_err, 1);
    chk("t3_err_noack", lsu_ack, 0);
    tick(); s_err = 0; settle();
    chk("t3_release2", s_stb, 1);
    chk("t3_release2_adr", s_adr, 32'h114);

    // 4: same-cycle accept and ack, then spurious ack at zero
    tick(); lsu_stb = 0; s_ack = 1; settle();
    chk("t4_cnt4", dut.r_outst, 4);
    tick(); settle();
    tick(); lsu_stb = 1; lsu_adr = 32'h118; settle();
    chk("t4_cnt2", dut.r_outst, 2);
    chk("t4_stb", s_stb, 1);
    chk("t4_ack", lsu_ack, 1);
    tick(); lsu_stb = 0; settle();
    chk("t4_cnt_hold", dut.r_outst, 2);
    tick(); settle();
    tick(); settle();
    chk("t4_cnt0", dut.r_outst, 0);
    chk("t4_spurious", lsu_ack, 0);
    chk("t4_still_cyc", s_cyc, 1);

    // 5: LSU aborts with two outstanding while fetch waits
    tick(); s_ack = 0; lsu_stb = 1; lsu_adr = 32'h120; if_cyc = 1; if_stb = 0; settle();
    chk("t5_cnt_sat", dut.r_outst, 0);
    chk("t5_if_wait", if_stall, 1);
    tick(); lsu_adr = 32'h124; settle();
    tick(); lsu_cyc = 0; lsu_stb = 0; s_ack = 1; settle();
    chk("t5_cnt2", dut.r_outst, 2);
    chk("t5_abort_cyc", s_cyc, 0);
    chk("t5_late1_lsu", lsu_ack, 0);
    chk("t5_late1_if", if_ack, 0);
    tick(); settle();
    chk("t5_if_gnt", s_cyc, 1);
    chk("t5_if_stall", if_stall, 0);
    chk("t5_late2_if", if_ack, 0);
    chk("t5_late2_lsu", lsu_ack, 0);
    chk("t5_cnt_clr", dut.r_outst, 0);

    // 6: asynchronous reset mid-burst, then fresh grant
    tick(); s_ack = 0; if_stb = 1; if_adr = 32'h40; settle();
    chk("t6_stb", s_stb, 1);
    tick(); if_adr = 32'h44; #1; rstn = 0; s_ack = 1; #1;
    chk("t6_rst_cyc", s_cyc, 0);
    chk("t6_rst_stb", s_stb, 0);
    chk("t6_rst_adr", s_adr, 0);
    chk("t6_rst_if_stall", if_stall, 1);
    chk("t6_rst_lsu_stall", lsu_stall, 1);
    chk("t6_rst_ack", if_ack, 0);
    #1; rstn = 1; s_ack = 0; #1;
    chk("t6_post_idle", s_cyc, 0);
    tick(); settle();
    chk("t6_regrant_cyc", s_cyc, 1);
    chk("t6_regrant_stb", s_stb, 1);
    chk("t6_regrant_adr", s_adr, 32'h44);
    chk("t6_regrant_cnt", dut.r_outst, 0);
    tick(); if_cyc = 0; if_stb = 0; settle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/wb_core_arbiter.md
# wb_core_arbiter

Two-to-one Wishbone B4 pipelined arbiter that shares a single bus master port between the core's instruction-fetch master and LSU master. It is used when both core ports target one single-ported memory or interconnect port. Ownership is granted per bus cycle (`cyc`), and a master keeps the bus until its `cyc` drops. The arbiter tracks outstanding requests so that responses always route to the owner and the owner cannot exceed the outstanding limit.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `sel` width is `DATA_W/8`
- `MAX_OUTST`, 4, maximum accepted-but-unacknowledged requests (≥1)
- `clk_i`  in  1  clock
- `rstn_i`  in  1  asynchronous active-low reset
- `if_cyc_i, if_stb_i, if_we_i`  in  1 each  fetch master control
- `if_adr_i`  in  `ADDR_W`; `if_sel_i`  in  `DATA_W/8`; `if_dat_i`  in  `DATA_W`  fetch request
- `if_dat_o`  out  `DATA_W`; `if_ack_o, if_err_o, if_stall_o`  out  1  fetch response
- `lsu_*`  same set as `if_*`  LSU master
- `s_cyc_o, s_stb_o, s_we_o`  out  1; `s_adr_o`  out  `ADDR_W`; `s_sel_o`  out  `DATA_W/8`; `s_dat_o`  out  `DATA_W`  shared port
- `s_dat_i`  in  `DATA_W`; `s_ack_i, s_err_i, s_stall_i`  in  1  shared port response

## Operation
- FSM states: IDLE, GNT_IF, GNT_LSU. `last` flag records the most recently granted master. `outst` counter has width `$clog2(MAX_OUTST+1)`.
- Transitions from IDLE, or from a grant state in the cycle the owner's `cyc` is low:
  - Only one master's `cyc` is high → grant that master.
  - Both are high → grant the master not equal to `last`.
  - Neither is high → go to IDLE.
- When the grant is taken, update `last` and clear `outst`.
- Owner drops `cyc` with `outst>0` (abort): `s_cyc_o` drops the same cycle. Late `s_ack_i`/`s_err_i` are discarded and never reach either master.
- Shared-port outputs:
  - `s_cyc_o = owner_cyc`.
  - `s_stb_o = owner_cyc & owner_stb & (outst<MAX_OUTST)`.
  - `we`, `adr`, `sel`, `dat` are muxed from the owner; all are 0 in IDLE.
- Owner side:
  - `stall_o = s_stall_i | (outst==MAX_OUTST)`.
  - `ack_o = s_ack_i & s_cyc_o`; `err_o = s_err_i & s_cyc_o`.
- Non-owner side: `stall_o=1`, `ack_o=0`, `err_o=0`.
- `if_dat_o = lsu_dat_o = s_dat_i` (broadcast); it is only meaningful with `ack`.
- `outst` update rules:
  - +1 on accept (`s_stb_o & ~s_stall_i`); −1 on `s_ack_i|s_err_i` while `s_cyc_o`.
  - Accept and response in the same cycle → unchanged.
  - A response at `outst==0` is ignored; the counter saturates at 0.
  - The counter never exceeds `MAX_OUTST`.
- Reset (asynchronous, any cycle, including mid-transaction):
  - State IDLE, `outst=0`, `last=LSU`, so fetch wins the first tie.
  - All `s_*_o` are 0; both `stall_o=1`, both `ack_o`/`err_o=0`.

## Timing
- Grant latency is 1 cycle: a `cyc` rising in IDLE produces the grant register at the next edge, and `s_cyc_o`/`s_stb_o` appear that cycle.
- All shared-port and response paths are combinational through the registered grant. There is no added request or response latency once granted.
- Ownership change has at least one `s_cyc_o`-low cycle between owners, namely the release cycle. Back-to-back requesters have no additional idle cycle.
- A master that holds `cyc` continuously is never preempted. Fairness applies only at cycle boundaries.
- An `ack` arriving in the same cycle the owner releases `cyc` is not delivered. Masters must keep `cyc` high until all acks return.

## Test plan
1. Reset, then fetch issues 3 pipelined reads to 0x0, 0x4, 0x8 with slave ack 2 cycles later. Required: `s_cyc_o` asserts one cycle after `if_cyc_i`, `if_ack_o` pulses 3 times with the slave data, and `lsu_stall_o` stays 1 throughout.
2. Both `cyc` rise in the same cycle after reset. Required: fetch is granted first. After fetch releases, LSU is granted with exactly one `s_cyc_o`-low cycle between. The next tie goes to fetch again, since `last` is now LSU.
3. `MAX_OUTST=4` with slave withholding ack and LSU issuing 6 stores. Required: 4 are accepted, `lsu_stall_o=1` and `s_stb_o=0` while `outst==4`, and each ack releases one more store.
4. Same-cycle accept and ack at `outst=2`. Required: `outst` stays 2. A spurious `s_ack_i` at `outst=0` leaves it at 0 with no master `ack`.
5. LSU aborts (drops `cyc`) with 2 outstanding while fetch waits. Required: `s_cyc_o` drops immediately, fetch is granted next cycle, and the two late acks are not seen by either master.
6. Assert `rstn_i` low mid-burst. Required: outputs go to reset values asynchronously, and after release the arbiter accepts a fresh request with 1-cycle grant latency.
